// File: rtl/imem_fetch_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_port_pkg
//  Description : Shared types and constants for the instruction-memory fetch
//                port: FSM state encoding, error-cause codes, the NOP word
//                that a zeroed fetch is decoded as, and the first-error
//                latching helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_fetch_port_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } fetch_state_t;

  localparam logic [1:0]  ERR_NONE     = 2'b00;
  localparam logic [1:0]  ERR_MISALIGN = 2'b01;
  localparam logic [1:0]  ERR_RANGE    = 2'b10;
  localparam logic [1:0]  ERR_TIMEOUT  = 2'b11;

  localparam logic [31:0] NOP_WORD     = 32'h5400_0000;

  // Only the first error is recorded; once the sticky flag is set the cause
  // already held is kept.
  function automatic logic [1:0] first_err_cause(input logic       err_flag,
                                                 input logic [1:0] cur_cause,
                                                 input logic [1:0] new_cause);
    return err_flag ? cur_cause : new_cause;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_buffer
//  Description : Single-entry last-fetch buffer (tag/data/valid).
//  Ports       : clk, rst          - clock, async active-high reset
//                lookup_addr       - byte address compared against the tag
//                hit               - valid entry matches lookup_addr
//                hit_data          - buffered instruction word
//                capture_en        - load capture_addr/capture_data, set valid
//                capture_addr/data - new tag and data
//                invalidate        - clear valid at the next edge
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_buffer
  import imem_fetch_port_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_addr,
  output logic        hit,
  output logic [31:0] hit_data,
  input  logic        capture_en,
  input  logic [31:0] capture_addr,
  input  logic [31:0] capture_data,
  input  logic        invalidate
);

  logic        r_valid;
  logic [31:0] r_tag;
  logic [31:0] r_data;

  // A capture in the same cycle as invalidate wins: the new word came from
  // the rewritten memory, so it is current.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (capture_en) begin
      r_valid <= 1'b1;
      r_tag   <= capture_addr;
      r_data  <= capture_data;
    end else if (invalidate) begin
      r_valid <= 1'b0;
    end
  end

  // A lookup coinciding with invalidate must already see the entry as gone.
  assign hit      = r_valid && !invalidate && (r_tag == lookup_addr);
  assign hit_data = r_data;

endmodule
`default_nettype wire

// File: rtl/imem_fetch_port.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_port
//  Description : Instruction-memory access port feeding the fetch stage.
//                Accepts a start_read pulse with a byte address, checks it,
//                serves repeated PCs from a one-entry buffer, otherwise runs
//                a req/ack memory read with wait states and a timeout, and
//                returns read_data with a one-cycle ready pulse.
//  Ports       : clk, rst            - clock, async active-high reset
//                start_read, address - fetch request (sampled in IDLE)
//                invalidate          - drop the buffered fetch
//                read_data, ready    - fetched word, one-cycle valid pulse
//                mem_req, mem_addr   - memory request and word address
//                mem_rdata, mem_ack  - memory data and acknowledge
//                fetch_error         - sticky error flag
//                err_cause           - cause of the first error
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_port
  import imem_fetch_port_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int MEM_WORDS = 16384,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_read,
  input  logic [31:0]       address,
  input  logic              invalidate,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              fetch_error,
  output logic [1:0]        err_cause
);

  // 33-bit limit so the full 32-bit address compares correctly even when
  // MEM_WORDS*4 does not fit in 32 bits.
  localparam logic [32:0] c_addr_limit = 33'(MEM_WORDS) * 33'd4;
  localparam logic [7:0]  c_timeout    = 8'(TIMEOUT);

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [7:0]        r_count;
  logic [7:0]        w_count_inc;
  logic [31:0]       r_req_addr;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_read_data;
  logic              r_fetch_error;
  logic [1:0]        r_err_cause;

  logic              w_misaligned;
  logic              w_out_of_range;
  logic              w_timeout;
  logic              w_hit;
  logic [31:0]       w_hit_data;

  logic              w_accept_miss;
  logic              w_capture;
  logic              w_load_hit;
  logic              w_load_zero;
  logic              w_err_set;
  logic [1:0]        w_err_code;

  imem_fetch_buffer u_buffer (
    .clk          (clk),
    .rst          (rst),
    .lookup_addr  (address),
    .hit          (w_hit),
    .hit_data     (w_hit_data),
    .capture_en   (w_capture),
    .capture_addr (r_req_addr),
    .capture_data (mem_rdata),
    .invalidate   (invalidate)
  );

  assign w_misaligned   = (address[1:0] != 2'b00);
  assign w_out_of_range = ({1'b0, address} >= c_addr_limit);

  // Saturating wait counter. The fetch aborts on the edge at which the
  // counter would reach TIMEOUT, so mem_req is high for at most TIMEOUT
  // cycles. An ack on that same edge still wins.
  assign w_count_inc = (r_count >= c_timeout) ? r_count : r_count + 8'd1;
  assign w_timeout   = !mem_ack && (w_count_inc >= c_timeout);

  always_comb begin
    w_state_next  = r_state;
    w_accept_miss = 1'b0;
    w_capture     = 1'b0;
    w_load_hit    = 1'b0;
    w_load_zero   = 1'b0;
    w_err_set     = 1'b0;
    w_err_code    = ERR_NONE;
    case (r_state)
      IDLE: begin
        if (start_read) begin
          if (w_misaligned) begin
            w_err_set    = 1'b1;
            w_err_code   = ERR_MISALIGN;
            w_load_zero  = 1'b1;
            w_state_next = RESP;
          end else if (w_out_of_range) begin
            w_err_set    = 1'b1;
            w_err_code   = ERR_RANGE;
            w_load_zero  = 1'b1;
            w_state_next = RESP;
          end else if (w_hit) begin
            w_load_hit   = 1'b1;
            w_state_next = RESP;
          end else begin
            w_accept_miss = 1'b1;
            w_state_next  = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          w_capture    = 1'b1;
          w_state_next = RESP;
        end else if (w_timeout) begin
          w_err_set    = 1'b1;
          w_err_code   = ERR_TIMEOUT;
          w_load_zero  = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_req_addr <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      if (w_accept_miss) begin
        r_count    <= '0;
        r_req_addr <= address;
        r_mem_addr <= address[ADDR_W+1:2];
      end else if ((r_state == REQ) && !mem_ack) begin
        r_count <= w_count_inc;
      end
      // REQ is only ever entered from a miss or held while waiting, so the
      // request line simply tracks the next state.
      r_mem_req <= (w_state_next == REQ);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read_data <= '0;
    end else if (w_capture) begin
      r_read_data <= mem_rdata;
    end else if (w_load_hit) begin
      r_read_data <= w_hit_data;
    end else if (w_load_zero) begin
      r_read_data <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_error <= 1'b0;
      r_err_cause   <= ERR_NONE;
    end else if (w_err_set) begin
      r_fetch_error <= 1'b1;
      r_err_cause   <= first_err_cause(r_fetch_error, r_err_cause, w_err_code);
    end
  end

  assign ready       = (r_state == RESP);
  assign read_data   = r_read_data;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign fetch_error = r_fetch_error;
  assign err_cause   = r_err_cause;

endmodule
`default_nettype wire
